fp_round_pipe: RTL and testbench

//  Parametrised, pipelined rounding stage for the FP adder/multiplier datapath.

---
 rtl/fp_round_pipe.sv | 104 ++++++++++
 tb/tb_fp_round_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage IEEE-754 rounding pipeline with valid/ready handshakes
module fp_round_pipe #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [MW:0]   in_mant,
  input  logic [2:0]    in_grs,
  input  logic          in_ovf,
  input  logic [2:0]    in_rm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW-1:0] out_exp,
  output logic [MW:0]   out_mant,
  output logic          out_ovf,
  output logic          out_inexact
);
  localparam logic [EW-1:0] E_MAX = '1;
  localparam logic [EW-1:0] E_TOP = {{(EW-1){1'b1}}, 1'b0};
  logic          s1_valid, s1_sign, s1_x, s1_ovf;
  logic [EW-1:0] s1_exp;
  logic [MW+1:0] s1_sum;
  logic [2:0]    s1_rm;
  logic          adv1, adv2;
  logic [2:0]    mode;
  logic          x, inc_raw, inc;
  logic [MW+1:0] sum;
  logic          carry, ovf, to_inf;
  logic [EW-1:0] n_exp, f_exp;
  logic [MW:0]   n_mant, f_mant;
  assign adv2     = !out_valid | out_ready;
  assign adv1     = !s1_valid | adv2;
  assign in_ready = adv1;
  // stage 1: pick the increment for the selected mode and add it to the mantissa
  always_comb begin
    mode    = in_rm > 3'd4 ? 3'd0 : in_rm;
    x       = |in_grs;
    inc_raw = mode == 3'd0 ? in_grs[2] & (in_grs[1] | in_grs[0] | in_mant[0]) :
              mode == 3'd1 ? 1'b0 :
              mode == 3'd2 ? in_sign & x :
              mode == 3'd3 ? !in_sign & x : in_grs[2];
    inc     = inc_raw & !(in_exp == E_MAX & !in_ovf);
    sum     = {1'b0, in_mant} + (MW+2)'(inc);
  end
  // stage 2: renormalise after carry, promote subnormals, saturate on overflow
  always_comb begin
    carry  = s1_sum[MW+1];
    ovf    = s1_ovf | (carry & s1_exp == E_TOP);
    n_exp  = carry ? s1_exp + EW'(1) :
             (s1_exp == '0 & !s1_ovf) ? {{(EW-1){1'b0}}, s1_sum[MW]} : s1_exp;
    n_mant = carry ? s1_sum[MW+1:1] : s1_sum[MW:0];
    to_inf = s1_rm == 3'd0 | s1_rm == 3'd4 | (s1_rm == 3'd3 & !s1_sign) | (s1_rm == 3'd2 & s1_sign);
    f_exp  = ovf ? (to_inf ? E_MAX : E_TOP) : n_exp;
    f_mant = ovf ? (to_inf ? '0 : '1) : n_mant;
  end
  // stage 1 register: loads a new beat whenever the stage can move
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_sum   <= '0;
      s1_x     <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_rm    <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_exp  <= in_exp;
        s1_sum  <= sum;
        s1_x    <= x;
        s1_ovf  <= in_ovf;
        s1_rm   <= mode;
      end
    end
  end
  // stage 2 register: output beat, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_exp     <= '0;
      out_mant    <= '0;
      out_ovf     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign    <= s1_sign;
        out_exp     <= f_exp;
        out_mant    <= f_mant;
        out_ovf     <= ovf;
        out_inexact <= s1_x | ovf;
      end
    end
  end
endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: randomized and directed checks of the rounding pipeline against a reference model
module tb_fp_round_pipe;
  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [23:0] m;
    logic [2:0] grs;
    logic       ov;
    logic [2:0] rm;
  } beat_t;
  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [23:0] m;
    logic       ov;
    logic       inx;
  } res_t;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, in_sign = 0, in_ovf = 0;
  logic [7:0] in_exp = 0;
  logic [23:0] in_mant = 0;
  logic [2:0] in_grs = 0, in_rm = 0;
  logic out_valid, out_ready = 1, out_sign, out_ovf, out_inexact;
  logic [7:0] out_exp;
  logic [23:0] out_mant;
  int total = 0, bad = 0;
  fp_round_pipe #(.EW(8), .MW(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp),
    .in_mant(in_mant), .in_grs(in_grs), .in_ovf(in_ovf), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
    .out_mant(out_mant), .out_ovf(out_ovf), .out_inexact(out_inexact)
  );
  always #5 clk = ~clk;
  // reference: round the value (mant + grs/8) to an integer mantissa by mode, then renormalise
  function automatic res_t model(input beat_t b);
    res_t r;
    int mode, frac, m, e;
    bit up, special, inf;
    mode = b.rm > 4 ? 0 : int'(b.rm);
    frac = int'(b.grs);
    special = (b.e == 8'hFF) && !b.ov;
    case (mode)
      0: up = frac > 4 || (frac == 4 && b.m[0]);
      1: up = 0;
      2: up = b.s && frac != 0;
      3: up = !b.s && frac != 0;
      default: up = frac >= 4;
    endcase
    if (special) up = 0;
    m = int'(b.m) + int'(up);
    e = int'(b.e);
    if (m >= (1 << 24)) begin
      m = m / 2;
      e = e + 1;
    end else if (b.e == 0 && !b.ov) e = (m >= (1 << 23)) ? 1 : 0;
    r.ov = b.ov || (e >= 255 && !special);
    if (r.ov) begin
      inf = mode == 0 || mode == 4 || (mode == 3 && !b.s) || (mode == 2 && b.s);
      e = inf ? 255 : 254;
      m = inf ? 0 : 24'hFFFFFF;
    end
    r.s = b.s;
    r.e = e[7:0];
    r.m = m[23:0];
    r.inx = frac != 0 || r.ov;
    return r;
  endfunction
  function automatic beat_t rand_beat();
    beat_t b;
    int sel;
    sel = $urandom_range(0, 7);
    b.e = sel == 0 ? 8'h00 : sel == 1 ? 8'h01 : sel == 2 ? 8'hFE : sel == 3 ? 8'hFF : 8'($urandom_range(1, 254));
    b.m = {b.e != 0, 23'($urandom)};
    if ($urandom_range(0, 3) == 0) b.m[22:0] = '1;
    b.s = 1'($urandom);
    b.grs = 3'($urandom);
    b.ov = $urandom_range(0, 9) == 0;
    b.rm = 3'($urandom);
    return b;
  endfunction
  task automatic drive(input beat_t b);
    in_sign = b.s;
    in_exp = b.e;
    in_mant = b.m;
    in_grs = b.grs;
    in_ovf = b.ov;
    in_rm = b.rm;
  endtask
  task automatic xfer(input beat_t b, output res_t r, output int lat);
    drive(b);
    in_valid = 1;
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    r = {out_sign, out_exp, out_mant, out_ovf, out_inexact};
    @(posedge clk); #1;
  endtask
  // streams n random beats; rdy_mode 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  task automatic run_stream(input int n, input int rdy_mode, output int first_c, output int last_c);
    beat_t beats[$];
    res_t want, got, held;
    int sent = 0, rcv = 0, c = 0;
    bit stall_prev = 0, acc;
    for (int i = 0; i < n; i++) beats.push_back(rand_beat());
    first_c = -1;
    last_c = -1;
    while (rcv < n && c < 400) begin
      out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom);
      if (sent < n) begin
        drive(beats[sent]);
        in_valid = 1;
      end else in_valid = 0;
      #2;
      got = {out_sign, out_exp, out_mant, out_ovf, out_inexact};
      if (stall_prev) begin
        total++;
        if (!out_valid || got !== held) begin
          bad++;
          $display("FAIL stall_hold: valid=%b data=%h want valid=1 data=%h", out_valid, got, held);
        end
      end
      if (out_valid && out_ready) begin
        want = model(beats[rcv]);
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL stream_beat%0d: got %h want %h", rcv, got, want);
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        rcv++;
      end
      stall_prev = out_valid && !out_ready;
      held = got;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      c++;
    end
    total++;
    if (rcv != n) begin
      bad++;
      $display("FAIL stream_count: got %0d beats want %0d", rcv, n);
    end
    in_valid = 0;
    out_ready = 1;
  endtask
  task automatic test_reset();
    rst = 1;
    in_valid = 0;
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst = 0;
    @(posedge clk); #1;
    total++;
    if ({out_valid, out_sign, out_exp, out_mant, out_ovf, out_inexact} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %b_%b_%h_%h_%b_%b want all zero",
               out_valid, out_sign, out_exp, out_mant, out_ovf, out_inexact);
    end
  endtask
  task automatic test_directed();
    beat_t b[13];
    res_t w[13];
    res_t r;
    int lat;
    b[0]  = {1'b0, 8'h80, 24'h800001, 3'b100, 1'b0, 3'd0}; w[0]  = {1'b0, 8'h80, 24'h800002, 1'b0, 1'b1};
    b[1]  = {1'b0, 8'h80, 24'h800002, 3'b100, 1'b0, 3'd0}; w[1]  = {1'b0, 8'h80, 24'h800002, 1'b0, 1'b1};
    b[2]  = {1'b0, 8'h7F, 24'hFFFFFF, 3'b110, 1'b0, 3'd0}; w[2]  = {1'b0, 8'h80, 24'h800000, 1'b0, 1'b1};
    b[3]  = {1'b0, 8'hFE, 24'hFFFFFF, 3'b111, 1'b0, 3'd0}; w[3]  = {1'b0, 8'hFF, 24'h000000, 1'b1, 1'b1};
    b[4]  = {1'b0, 8'hFE, 24'hFFFFFF, 3'b111, 1'b0, 3'd1}; w[4]  = {1'b0, 8'hFE, 24'hFFFFFF, 1'b0, 1'b1};
    b[5]  = {1'b1, 8'hFE, 24'hFFFFFF, 3'b111, 1'b0, 3'd3}; w[5]  = {1'b1, 8'hFE, 24'hFFFFFF, 1'b0, 1'b1};
    b[6]  = {1'b0, 8'h00, 24'h7FFFFF, 3'b100, 1'b0, 3'd4}; w[6]  = {1'b0, 8'h01, 24'h800000, 1'b0, 1'b1};
    b[7]  = {1'b1, 8'hFE, 24'hFFFFFF, 3'b111, 1'b0, 3'd2}; w[7]  = {1'b1, 8'hFF, 24'h000000, 1'b1, 1'b1};
    b[8]  = {1'b0, 8'h90, 24'h812345, 3'b000, 1'b1, 3'd1}; w[8]  = {1'b0, 8'hFE, 24'hFFFFFF, 1'b1, 1'b1};
    b[9]  = {1'b0, 8'h80, 24'h800001, 3'b100, 1'b0, 3'd6}; w[9]  = {1'b0, 8'h80, 24'h800002, 1'b0, 1'b1};
    b[10] = {1'b1, 8'hFF, 24'hC00001, 3'b111, 1'b0, 3'd4}; w[10] = {1'b1, 8'hFF, 24'hC00001, 1'b0, 1'b1};
    b[11] = {1'b0, 8'h81, 24'h9ABCDE, 3'b000, 1'b0, 3'd3}; w[11] = {1'b0, 8'h81, 24'h9ABCDE, 1'b0, 1'b0};
    b[12] = {1'b0, 8'h80, 24'h800003, 3'b011, 1'b0, 3'd0}; w[12] = {1'b0, 8'h80, 24'h800003, 1'b0, 1'b1};
    for (int i = 0; i < 13; i++) begin
      xfer(b[i], r, lat);
      total++;
      if (r !== w[i] || lat != 1) begin
        bad++;
        $display("FAIL directed%0d: got %h lat=%0d want %h lat=1", i, r, lat, w[i]);
      end
    end
  endtask
  task automatic test_random();
    int f, l;
    run_stream(64, 0, f, l);
    run_stream(64, 2, f, l);
  endtask
  task automatic test_backpressure();
    int f, l;
    run_stream(8, 1, f, l);
    total++;
    if (l - f <= 7) begin
      bad++;
      $display("FAIL backpressure_span: got %0d cycles want more than 7", l - f);
    end
  endtask
  task automatic test_back_to_back();
    int f, l;
    run_stream(8, 0, f, l);
    total++;
    if (f != 2 || l - f != 7) begin
      bad++;
      $display("FAIL back_to_back: got first=%0d span=%0d want first=2 span=7", f, l - f);
    end
  endtask
  task automatic test_reset_midstream();
    logic [33:0] held;
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      drive(rand_beat());
      in_valid = 1;
      @(posedge clk); #1;
    end
    held = {out_sign, out_exp, out_mant, out_ovf};
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL full_stall: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_sign, out_exp, out_mant, out_ovf} !== held) begin
      bad++;
      $display("FAIL full_hold: got in_ready=%b out_valid=%b data=%h want 0 1 %h",
               in_ready, out_valid, {out_sign, out_exp, out_mant, out_ovf}, held);
    end
    rst = 1;
    in_valid = 0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_exp !== 8'h00 || out_mant !== 24'h0) begin
      bad++;
      $display("FAIL midstream_flush: got valid=%b in_ready=%b exp=%h mant=%h want 0 1 00 000000",
               out_valid, in_ready, out_exp, out_mant);
    end
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL stale_beat%0d: got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
